// File: rtl/time_ctrl_pkg.sv
// Shared constants for the watch/stopwatch control unit.
// Holds the state encoding and a counter-width helper.
package time_ctrl_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] PAUSE = 3'd2;
  localparam logic [2:0] SET   = 3'd3;
  localparam logic [2:0] CLEAR = 3'd4;

  // Bits needed to hold 0..max; never less than one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/time_ctrl_fsm_autorepeat.sv
// Hold-to-auto-repeat for one direction button.
// Ports: clk, reset, i_tick, i_en, i_lvl, i_block -> o_fire (1-cycle pulse).
module btn_autorepeat
  import time_ctrl_pkg::*;
#(
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_en,
  input  logic i_lvl,
  input  logic i_block,
  output logic o_fire
);

  localparam int HW = cnt_w(HOLD_TICKS);
  localparam int RW = cnt_w(REPEAT_TICKS);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_TICKS);

  logic          lvl_q;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          active;
  logic          holding;
  logic          press;
  logic          hold_hit;
  logic          rep_hit;

  // lvl_q follows the raw level even when blocked, so
  // releasing the opposite button never looks like a press.
  assign active   = i_en & i_lvl & ~i_block;
  assign holding  = (hold_cnt == HOLD_MAX);
  assign press    = active & ~lvl_q;
  assign hold_hit = active & i_tick & ~holding &
                    (hold_cnt == HOLD_MAX - 1'b1);
  assign rep_hit  = active & i_tick & holding &
                    (rep_cnt == REP_MAX - 1'b1);
  assign o_fire   = press | hold_hit | rep_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q    <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      lvl_q <= i_lvl;
      if (!active) begin
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else if (i_tick) begin
        if (!holding)
          hold_cnt <= hold_cnt + 1'b1;
        else if (rep_hit)
          rep_cnt <= '0;
        else
          rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_ctrl_fsm.sv
// Control FSM for watch/stopwatch: run/pause/clear, field setting,
// auto-repeat inc/dec, SET timeout, blink and lap freeze.
module time_ctrl_fsm
  import time_ctrl_pkg::*;
#(
  parameter int NUM_FIELDS    = 4,
  parameter int HOLD_TICKS    = 50,
  parameter int REPEAT_TICKS  = 10,
  parameter int TIMEOUT_TICKS = 1000,
  parameter int BLINK_TICKS   = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_tick,
  input  logic                  i_btn_run,
  input  logic                  i_btn_clear,
  input  logic                  i_btn_set,
  input  logic                  i_btn_sel,
  input  logic                  i_btn_lap,
  input  logic                  i_up_lvl,
  input  logic                  i_down_lvl,
  output logic                  o_run,
  output logic                  o_clear,
  output logic                  o_setting,
  output logic [NUM_FIELDS-1:0] o_field_sel,
  output logic [NUM_FIELDS-1:0] o_inc,
  output logic [NUM_FIELDS-1:0] o_dec,
  output logic                  o_blink,
  output logic                  o_lap_hold
);

  if (NUM_FIELDS < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1 ||
      TIMEOUT_TICKS < 1 || BLINK_TICKS < 1) begin : g_bad_param
    $error("time_ctrl_fsm: parameters must be non-zero");
  end

  localparam int TW = cnt_w(TIMEOUT_TICKS);
  localparam int BW = cnt_w(BLINK_TICKS);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_TICKS);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_TICKS);

  logic [2:0]            state;
  logic [2:0]            nxt;
  logic [TW-1:0]         tmo_cnt;
  logic [BW-1:0]         blk_cnt;
  logic                  in_set;
  logic                  activity;
  logic                  timeout;
  logic                  sel_go;
  logic                  lap_go;
  logic                  up_fire;
  logic                  dn_fire;
  logic [NUM_FIELDS-1:0] fs_rot;

  assign in_set    = (state == SET);
  assign o_run     = (state == RUN);
  assign o_setting = in_set;
  assign o_clear   = (state == CLEAR);

  assign activity = i_btn_run | i_btn_clear | i_btn_set |
                    i_btn_sel | i_btn_lap | i_up_lvl | i_down_lvl;
  assign timeout  = in_set & i_tick & ~activity &
                    (tmo_cnt == TMO_MAX - 1'b1);

  // Left rotate with wrap; also correct for a single field.
  assign fs_rot = (o_field_sel << 1) |
                  (o_field_sel >> (NUM_FIELDS - 1));

  always_comb begin
    nxt    = state;
    lap_go = 1'b0;
    sel_go = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_btn_clear)    nxt = CLEAR;
        else if (i_btn_set) nxt = SET;
        else if (i_btn_run) nxt = RUN;
      end
      RUN: begin
        if (i_btn_clear)    nxt = CLEAR;
        else if (i_btn_set) nxt = SET;
        else if (i_btn_run) nxt = PAUSE;
        else                lap_go = i_btn_lap;
      end
      PAUSE: begin
        if (i_btn_clear)    nxt = CLEAR;
        else if (i_btn_set) nxt = SET;
        else if (i_btn_run) nxt = RUN;
      end
      SET: begin
        if (i_btn_clear)    nxt = CLEAR;
        else if (i_btn_set) nxt = RUN;
        else if (timeout)   nxt = RUN;
        else                sel_go = i_btn_sel;
      end
      CLEAR:   nxt = PAUSE;
      default: nxt = IDLE;
    endcase
  end

  btn_autorepeat #(
    .HOLD_TICKS   (HOLD_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) u_up (
    .clk     (clk),
    .reset   (reset),
    .i_tick  (i_tick),
    .i_en    (in_set),
    .i_lvl   (i_up_lvl),
    .i_block (i_down_lvl),
    .o_fire  (up_fire)
  );

  btn_autorepeat #(
    .HOLD_TICKS   (HOLD_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) u_dn (
    .clk     (clk),
    .reset   (reset),
    .i_tick  (i_tick),
    .i_en    (in_set),
    .i_lvl   (i_down_lvl),
    .i_block (i_up_lvl),
    .o_fire  (dn_fire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      o_field_sel <= NUM_FIELDS'(1);
      o_inc       <= '0;
      o_dec       <= '0;
      o_lap_hold  <= 1'b0;
      o_blink     <= 1'b0;
      tmo_cnt     <= '0;
      blk_cnt     <= '0;
    end else begin
      state <= nxt;
      // Strobes latch the field before any same-cycle sel moves it.
      o_inc <= up_fire ? o_field_sel : '0;
      o_dec <= dn_fire ? o_field_sel : '0;
      if (sel_go)
        o_field_sel <= fs_rot;

      if (nxt == CLEAR || nxt == SET)
        o_lap_hold <= 1'b0;
      else if (lap_go)
        o_lap_hold <= ~o_lap_hold;

      if (!in_set || activity)
        tmo_cnt <= '0;
      else if (i_tick && tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (nxt != SET) begin
        o_blink <= 1'b0;
        blk_cnt <= '0;
      end else if (!in_set) begin
        o_blink <= 1'b1;
        blk_cnt <= '0;
      end else if (i_tick) begin
        if (blk_cnt == BLK_MAX - 1'b1) begin
          blk_cnt <= '0;
          o_blink <= ~o_blink;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
    end
  end

endmodule
